// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with one registered output stage; fixed-select or round-robin mode.
// Optional packet lock (grant held until in_last) enabled by defining STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr #(
  parameter int unsigned NUM_IN = 5,
  parameter int unsigned DATA_W = 64,
  localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_rr,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN-1:0]        in_last,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_src,
  input  logic                     out_ready,
  output logic                     err_sel
);

  // One extra bit so rr_ptr + offset and the NUM_IN bound never overflow.
  localparam int unsigned IDX_W = SEL_W + 1;
  localparam logic [IDX_W-1:0] NUM_IN_I = IDX_W'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  logic [DATA_W-1:0] chan_data [NUM_IN];

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_ptr_nxt;

  logic             load_en_c;
  logic             sel_in_range_c;
  logic             sel_bad_c;
  logic             fix_vld_c;
  logic             rr_vld_c;
  logic [SEL_W-1:0] rr_idx_c;
  logic [IDX_W-1:0] cand_c;
  logic             grant_vld_c;
  logic [SEL_W-1:0] grant_c;
  logic             xfer_c;
  logic             locked_c;
  logic [SEL_W-1:0] lock_idx_c;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
    assign chan_data[i] = in_data[i*DATA_W +: DATA_W];
  end

  assign load_en_c      = !out_valid || out_ready;
  assign sel_in_range_c = ({1'b0, sel} < NUM_IN_I);
  assign sel_bad_c      = !mode_rr && !sel_in_range_c;
  assign fix_vld_c      = sel_in_range_c && in_valid[sel];

`ifdef STREAM_MUX_PKT_LOCK_EN
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] lock_idx;
  logic [SEL_W-1:0] lock_idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

  // Lock onto a channel at the first non-final beat; release on its final beat.
  always_comb begin
    state_nxt    = state;
    lock_idx_nxt = lock_idx;
    case (state)
      IDLE: begin
        if (xfer_c && !in_last[grant_c]) begin
          state_nxt    = LOCKED;
          lock_idx_nxt = grant_c;
        end
      end
      LOCKED: begin
        if (xfer_c && in_last[grant_c]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign locked_c   = (state == LOCKED);
  assign lock_idx_c = lock_idx;
`else
  assign locked_c   = 1'b0;
  assign lock_idx_c = '0;
`endif

  // Round-robin search: first valid channel starting at rr_ptr, wrapping at NUM_IN-1.
  always_comb begin
    rr_vld_c = 1'b0;
    rr_idx_c = '0;
    cand_c   = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      cand_c = {1'b0, rr_ptr} + IDX_W'(k);
      if (cand_c >= NUM_IN_I) begin
        cand_c = cand_c - NUM_IN_I;
      end
      if (!rr_vld_c && in_valid[cand_c[SEL_W-1:0]]) begin
        rr_vld_c = 1'b1;
        rr_idx_c = cand_c[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    grant_vld_c = 1'b0;
    grant_c     = '0;
    if (locked_c) begin
      grant_vld_c = in_valid[lock_idx_c];
      grant_c     = lock_idx_c;
    end else if (mode_rr) begin
      grant_vld_c = rr_vld_c;
      grant_c     = rr_idx_c;
    end else begin
      grant_vld_c = fix_vld_c;
      grant_c     = sel;
    end
  end

  assign xfer_c = grant_vld_c && load_en_c;

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      in_ready[i] = xfer_c && (grant_c == SEL_W'(i));
    end
  end

  // Pointer moves past the granted channel on RR or locked transfers only.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (xfer_c && (mode_rr || locked_c)) begin
      rr_ptr_nxt = (grant_c == LAST_IDX) ? '0 : grant_c + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      err_sel   <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      err_sel <= sel_bad_c;
      rr_ptr  <= rr_ptr_nxt;
      if (load_en_c) begin
        out_valid <= xfer_c;
        if (xfer_c) begin
          out_data <= chan_data[grant_c];
          out_last <= in_last[grant_c];
          out_src  <= grant_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus random traffic vs. a reference model.
module tb_stream_mux_rr;

  localparam int unsigned NUM_IN = 5;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SEL_W  = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     mode_rr;
  logic [SEL_W-1:0]         sel;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_last;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic                     out_last;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_src;
  logic                     out_ready;
  logic                     err_sel;

  stream_mux_rr #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_rr   (mode_rr),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .err_sel   (err_sel)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state: what the output register should hold.
  bit                m_valid;
  bit                m_last;
  logic [DATA_W-1:0] m_data;
  int                m_src;
  bit                m_err;
  int                m_ptr;
  bit                m_locked;
  int                m_lock_idx;
  logic [NUM_IN-1:0] last_rdy;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_last = 0; m_data = '0; m_src = 0; m_err = 0;
    m_ptr = 0; m_locked = 0; m_lock_idx = 0;
  endtask

  function automatic int model_grant();
    int g;
    g = -1;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (m_locked) return in_valid[m_lock_idx] ? m_lock_idx : -1;
`endif
    if (!mode_rr) begin
      if (int'(sel) < NUM_IN) begin
        if (in_valid[sel]) g = int'(sel);
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (g < 0 && in_valid[(m_ptr + k) % NUM_IN]) g = (m_ptr + k) % NUM_IN;
      end
    end
    return g;
  endfunction

  task automatic model_clock(input int g);
    bit load;
    bit was_locked;
    load       = !m_valid || out_ready;
    was_locked = m_locked;
    if (load) begin
      if (g >= 0) begin
        m_data  = in_data[g*DATA_W +: DATA_W];
        m_last  = in_last[g];
        m_src   = g;
        m_valid = 1;
        if (mode_rr || was_locked) m_ptr = (g + 1) % NUM_IN;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (!was_locked && !in_last[g]) begin
          m_locked   = 1;
          m_lock_idx = g;
        end else if (was_locked && in_last[g]) begin
          m_locked = 0;
        end
`endif
      end else begin
        m_valid = 0;
      end
    end
    m_err = !mode_rr && (int'(sel) >= NUM_IN);
  endtask

  // One clock: inputs already driven after a falling edge.
  task automatic step();
    int g;
    logic [NUM_IN-1:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0 && (!m_valid || out_ready)) exp_rdy[g] = 1'b1;
    last_rdy = in_ready;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    model_clock(g);
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_data",  out_data, m_data);
    check("out_src",   64'(out_src), 64'(m_src));
    check("out_last",  64'(out_last), 64'(m_last));
    check("err_sel",   64'(err_sel), 64'(m_err));
  endtask

  task automatic set_chan(input int i, input logic [DATA_W-1:0] v);
    in_data[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NUM_IN; i++) set_chan(i, {$urandom(), $urandom()});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data, 64'd0);
    check("rst_out_src",   64'(out_src), 64'd0);
    check("rst_err_sel",   64'(err_sel), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_t5 [4];

  initial begin
    mode_rr = 0; sel = '0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Fixed select
    for (int i = 0; i < NUM_IN; i++) set_chan(i, 64'(16'h1000 + i));
    set_chan(2, 64'hA5A5);
    set_chan(3, 64'h3333);
    mode_rr = 0; sel = 3'd2; in_valid = '1; in_last = '1; out_ready = 1;
    step();
    check("t1_in_ready", 64'(last_rdy), 64'(5'b00100));
    check("t1_data", out_data, 64'hA5A5);
    check("t1_src",  64'(out_src), 64'd2);

    // Backpressure holds the register, then reloads with no bubble
    out_ready = 0; sel = 3'd3;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t2_hold_data", out_data, 64'hA5A5);
      check("t2_hold_rdy",  64'(last_rdy), 64'd0);
    end
    out_ready = 1;
    step();
    check("t2_reload_valid", 64'(out_valid), 64'd1);
    check("t2_reload_data",  out_data, 64'h3333);

    // Round robin with all channels valid, then a single channel
    mode_rr = 1; in_valid = '1;
    for (int c = 0; c < 7; c++) begin
      step();
      check("t3_rr_src", 64'(out_src), 64'(c % NUM_IN));
    end
    in_valid = 5'b01000;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t3_single_src", 64'(out_src), 64'd3);
    end

    // Out-of-range select
    mode_rr = 0; in_valid = '1; sel = 3'd5;
    step();
    check("t4_rdy5", 64'(last_rdy), 64'd0);
    check("t4_valid5", 64'(out_valid), 64'd0);
    check("t4_err5", 64'(err_sel), 64'd1);
    sel = 3'd7;
    step();
    check("t4_err7", 64'(err_sel), 64'd1);
    sel = 3'd1;
    step();
    check("t4_err1", 64'(err_sel), 64'd0);
    check("t4_valid1", 64'(out_valid), 64'd1);

    // Reset while a beat is held, then packet behaviour from a fresh pointer
    out_ready = 0;
    step();
    check("t6_pre_valid", 64'(out_valid), 64'd1);
    do_reset();
    out_ready = 1; mode_rr = 1; in_valid = '1;
`ifdef STREAM_MUX_PKT_LOCK_EN
    exp_t5 = '{0, 0, 0, 1};
`else
    exp_t5 = '{0, 1, 2, 3};
`endif
    for (int b = 0; b < 4; b++) begin
      in_last = {4'b1111, (b >= 2)};
      step();
      check("t5_src", 64'(out_src), 64'(exp_t5[b]));
    end

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      mode_rr   = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) sel = SEL_W'($urandom_range(0, 7));
      in_valid  = NUM_IN'($urandom());
      in_last   = NUM_IN'($urandom());
      out_ready = ($urandom_range(0, 9) < 7);
      randomize_data();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
